// File: rtl/rsc_pkg.sv
// Shared definitions for the RSC encoder family (encoder, interleaver, decoder).
package rsc_pkg;

  // Encoder control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_TAIL = 2'd2,
    ST_DONE = 2'd3
  } rsc_state_t;

  // Default (7,5) octal code, memory 2
  localparam int         RSC_MEM_DEF  = 2;
  localparam logic [2:0] RSC_G_FB_DEF = 3'o7;
  localparam logic [2:0] RSC_G_FF_DEF = 3'o5;

endpackage

// File: rtl/rsc_trellis_step.sv
// One combinational trellis step of a recursive systematic convolutional code.
// s[j-1] holds the value delayed j cycles. In tail mode the input is replaced
// by the feedback sum so that the recursion input a becomes zero.
module rsc_trellis_step #(
  parameter int             MEM  = 2,
  parameter logic [MEM:0]   G_FB = 3'b111,
  parameter logic [MEM:0]   G_FF = 3'b101
) (
  input  logic [MEM-1:0] s,
  input  logic           u,
  input  logic           tail,
  output logic           u_eff,
  output logic           p,
  output logic [MEM-1:0] s_next
);

  logic fb;
  logic ff;
  logic a;

  // Feedback/feedforward tap sums, parity and shifted register contents
  always_comb begin
    fb     = 1'b0;
    ff     = 1'b0;
    s_next = '0;
    for (int j = 1; j <= MEM; j++) begin
      fb = fb ^ (G_FB[j] & s[j-1]);
      ff = ff ^ (G_FF[j] & s[j-1]);
    end
    u_eff     = tail ? fb : u;
    a         = u_eff ^ fb;
    p         = (G_FF[0] & a) ^ ff;
    s_next[0] = a;
    for (int j = 1; j < MEM; j++) begin
      s_next[j] = s[j-1];
    end
  end

endmodule

// File: rtl/rsc_enc_param.sv
// Block RSC encoder with trellis termination. Accepts a K_LEN-bit block,
// encodes it MSB first at one step per cycle, appends MEM tail steps that
// drive the state back to zero, and presents systematic and parity streams
// as parallel words until the consumer takes them.
module rsc_enc_param
  import rsc_pkg::*;
#(
  parameter int K_LEN = 16,
  parameter int MEM   = 2,
  parameter     G_FB  = RSC_G_FB_DEF,
  parameter     G_FF  = RSC_G_FF_DEF
) (
  input  logic                 clk_p_i,
  input  logic                 reset_n_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [K_LEN-1:0]     data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [K_LEN+MEM-1:0] data_sys_o,
  output logic [K_LEN+MEM-1:0] data_enc_o,
  output logic                 busy_o
);

  localparam int N_STEP = K_LEN + MEM;
  localparam int CNT_W  = $clog2(K_LEN + MEM + 1);

  localparam logic [MEM:0]       FB        = G_FB;
  localparam logic [MEM:0]       FF        = G_FF;
  localparam logic [CNT_W-1:0]   LAST_ENC  = CNT_W'(K_LEN - 1);
  localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(N_STEP - 1);

  // Parameter sanity: bad polynomials or ranges must not elaborate
  if ($bits(G_FB) != MEM + 1 || $bits(G_FF) != MEM + 1) begin : g_bad_width
    $error("rsc_enc_param: polynomial width must be MEM+1");
  end
  if (G_FB[0] != 1'b1) begin : g_bad_fb
    $error("rsc_enc_param: G_FB[0] must be 1");
  end
  if (K_LEN < 2 || K_LEN > 4096 || MEM < 1 || MEM > 6) begin : g_bad_range
    $error("rsc_enc_param: K_LEN or MEM out of range");
  end

  rsc_state_t          state;
  rsc_state_t          state_nx;
  logic [K_LEN-1:0]    blk;
  logic [MEM-1:0]      sreg;
  logic [MEM-1:0]      s_next;
  logic [CNT_W-1:0]    cnt;
  logic                accept;
  logic                stepping;
  logic                tail;
  logic                u_eff;
  logic                p;

  assign accept   = in_valid_i & in_ready_o;
  assign tail     = (state == ST_TAIL);
  assign stepping = (state == ST_ENC) || (state == ST_TAIL);

  rsc_trellis_step #(
    .MEM  (MEM),
    .G_FB (FB),
    .G_FF (FF)
  ) u_step (
    .s      (sreg),
    .u      (blk[K_LEN-1]),
    .tail   (tail),
    .u_eff  (u_eff),
    .p      (p),
    .s_next (s_next)
  );

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (accept)            state_nx = ST_ENC;
      ST_ENC:  if (cnt == LAST_ENC)   state_nx = ST_TAIL;
      ST_TAIL: if (cnt == LAST_STEP)  state_nx = ST_DONE;
      ST_DONE: if (out_ready_i)       state_nx = ST_IDLE;
      default:                        state_nx = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Registered handshake/status flags, decoded from the upcoming state
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      in_ready_o  <= 1'b0;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      in_ready_o  <= (state_nx == ST_IDLE);
      out_valid_o <= (state_nx == ST_DONE);
      busy_o      <= (state_nx == ST_ENC) || (state_nx == ST_TAIL);
    end
  end

  // Step counter, encoder state and output shift registers
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt        <= '0;
      sreg       <= '0;
      data_sys_o <= '0;
      data_enc_o <= '0;
    end else if (accept) begin
      cnt        <= '0;
      sreg       <= '0;
      data_sys_o <= '0;
      data_enc_o <= '0;
    end else if (stepping) begin
      cnt        <= cnt + 1'b1;
      sreg       <= s_next;
      data_sys_o <= {data_sys_o[N_STEP-2:0], u_eff};
      data_enc_o <= {data_enc_o[N_STEP-2:0], p};
    end
  end

  // Captured block, shifted so the next information bit is always the MSB
  always_ff @(posedge clk_p_i) begin
    if (accept) begin
      blk <= data_i;
    end else if (state == ST_ENC) begin
      blk <= {blk[K_LEN-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_rsc_enc_param.sv
// Bench for rsc_enc_param: default (7,5) instance and a K=40/MEM=3 instance,
// compared against a behavioural block-encoding model.
`timescale 1ns/1ps
module tb_rsc_enc_param;

  localparam int K0 = 16;
  localparam int M0 = 2;
  localparam int N0 = K0 + M0;
  localparam int K1 = 40;
  localparam int M1 = 3;
  localparam int N1 = K1 + M1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          v0, r0, ov0, or0, b0;
  logic [K0-1:0] d0;
  logic [N0-1:0] sys0, enc0;
  logic          v1, r1, ov1, or1, b1;
  logic [K1-1:0] d1;
  logic [N1-1:0] sys1, enc1;

  rsc_enc_param #(.K_LEN(K0), .MEM(M0), .G_FB(3'b111), .G_FF(3'b101)) dut0 (
    .clk_p_i(clk), .reset_n_i(rst_n), .in_valid_i(v0), .in_ready_o(r0),
    .data_i(d0), .out_valid_o(ov0), .out_ready_i(or0),
    .data_sys_o(sys0), .data_enc_o(enc0), .busy_o(b0));

  rsc_enc_param #(.K_LEN(K1), .MEM(M1), .G_FB(4'b1011), .G_FF(4'b1101)) dut1 (
    .clk_p_i(clk), .reset_n_i(rst_n), .in_valid_i(v1), .in_ready_o(r1),
    .data_i(d1), .out_valid_o(ov1), .out_ready_i(or1),
    .data_sys_o(sys1), .data_enc_o(enc1), .busy_o(b1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: walk the code trellis bit by bit. State is an integer whose
  // bit j-1 is the value delayed j cycles; tap sums are parities of masks.
  function automatic void ref_enc(input logic [63:0] blk, input int k, input int mem,
                                  input int gfb, input int gff,
                                  output logic [63:0] sys, output logic [63:0] enc,
                                  output int fin);
    int st;
    int fbp, ffp, u, a, p;
    st  = 0;
    sys = '0;
    enc = '0;
    for (int i = 0; i < k + mem; i++) begin
      fbp = $countones((gfb >> 1) & st) & 1;
      ffp = $countones((gff >> 1) & st) & 1;
      u   = (i < k) ? int'(blk[k-1-i]) : fbp;
      a   = u ^ fbp;
      p   = ((gff & 1) & a) ^ ffp;
      st  = ((st << 1) | a) & ((1 << mem) - 1);
      sys = {sys[62:0], u[0]};
      enc = {enc[62:0], p[0]};
    end
    fin = st;
  endfunction

  function automatic logic rdy(input int sel);
    return (sel == 0) ? r0 : r1;
  endfunction

  function automatic logic ovl(input int sel);
    return (sel == 0) ? ov0 : ov1;
  endfunction

  // Present one block and drop valid after the acceptance edge; returns at
  // the first falling edge after acceptance.
  task automatic send(input int sel, input logic [63:0] dat);
    int n = 0;
    while (rdy(sel) !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("send%0d_ready", sel), 64'(rdy(sel)), 64'd1);
    if (sel == 0) begin v0 = 1'b1; d0 = dat[K0-1:0]; end
    else          begin v1 = 1'b1; d1 = dat[K1-1:0]; end
    @(negedge clk);
    if (sel == 0) begin v0 = 1'b0; d0 = K0'($urandom); end
    else          begin v1 = 1'b0; d1 = ~d1; end
  endtask

  task automatic wait_out(input int sel, input string tag, input int exp_lat);
    int n = 0;
    while (ovl(sel) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(n), 64'(exp_lat));
  endtask

  task automatic take(input int sel, input string tag);
    if (sel == 0) or0 = 1'b1; else or1 = 1'b1;
    @(negedge clk);
    or0 = 1'b0;
    or1 = 1'b0;
    if (sel == 0) check(tag, {61'd0, ov0, r0, b0}, 64'b010);
    else          check(tag, {61'd0, ov1, r1, b1}, 64'b010);
  endtask

  // Full transaction on one instance; returns the observed output words
  task automatic run_block(input int sel, input logic [63:0] dat, input string tag,
                           output logic [63:0] got_sys, output logic [63:0] got_enc);
    logic [63:0] es, ee;
    int fin;
    if (sel == 0) ref_enc(dat, K0, M0, 7, 5, es, ee, fin);
    else          ref_enc(dat, K1, M1, 11, 13, es, ee, fin);
    send(sel, dat);
    if (sel == 0) check({tag, "_busy"}, {62'd0, b0, r0}, 64'b10);
    else          check({tag, "_busy"}, {62'd0, b1, r1}, 64'b10);
    wait_out(sel, {tag, "_lat"}, (sel == 0) ? N0 : N1);
    got_sys = (sel == 0) ? 64'(sys0) : 64'(sys1);
    got_enc = (sel == 0) ? 64'(enc0) : 64'(enc1);
    check({tag, "_sys"}, got_sys, es);
    check({tag, "_enc"}, got_enc, ee);
    check({tag, "_state"}, (sel == 0) ? 64'(dut0.sreg) : 64'(dut1.sreg), 64'd0);
    take(sel, {tag, "_take"});
  endtask

  logic [63:0] gs, ge, es, ee, dat;
  logic [63:0] qs[$], qe[$];
  int fin, cyc, acc, outs, last_acc, spurious;

  initial begin
    rst_n = 1'b0;
    v0 = 1'b0; or0 = 1'b0; d0 = '0;
    v1 = 1'b0; or1 = 1'b0; d1 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ctl0", {61'd0, r0, ov0, b0}, 64'd0);
    check("rst_data0", {28'd0, sys0, enc0}, 64'd0);
    check("rst_ctl1", {61'd0, r1, ov1, b1}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready_rise", {62'd0, r0, r1}, 64'b11);

    // Zero block and impulse on the default code
    run_block(0, 64'h0, "zero", gs, ge);
    check("zero_sys_const", gs, 64'h00000);
    check("zero_enc_const", ge, 64'h00000);
    run_block(0, 64'h8000, "impulse", gs, ge);
    check("impulse_sys_const", gs, 64'h20003);
    check("impulse_enc_const", ge, 64'h3B6D9);

    // Backpressure: held output, second request waits for the handshake
    dat = 64'($urandom_range(16'hFFFF, 0));
    ref_enc(dat, K0, M0, 7, 5, es, ee, fin);
    send(0, dat);
    wait_out(0, "bp_lat", N0);
    v0 = 1'b1;
    d0 = K0'($urandom);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_hold%0d", i), {26'd0, ov0, r0, sys0, enc0},
            {26'd0, 1'b1, 1'b0, es[N0-1:0], ee[N0-1:0]});
      @(negedge clk);
    end
    dat = 64'(d0);
    ref_enc(dat, K0, M0, 7, 5, es, ee, fin);
    or0 = 1'b1;
    @(negedge clk);
    or0 = 1'b0;
    check("bp_release", {61'd0, ov0, r0, b0}, 64'b010);
    @(negedge clk);
    check("bp_accept2", {62'd0, r0, b0}, 64'b01);
    v0 = 1'b0;
    wait_out(0, "bp2_lat", N0);
    check("bp2_sys", 64'(sys0), es);
    check("bp2_enc", 64'(enc0), ee);
    take(0, "bp2_take");

    // Reset in the middle of encoding
    send(0, 64'hFFFF);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ctl", {61'd0, r0, ov0, b0}, 64'd0);
    check("midrst_data", {28'd0, sys0, enc0}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", {61'd0, r0, ov0, b0}, 64'b100);
    spurious = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (ov0 !== 1'b0 || b0 !== 1'b0) spurious++;
    end
    check("midrst_no_output", 64'(spurious), 64'd0);
    run_block(0, 64'hFFFF, "after_rst", gs, ge);

    // Back-to-back traffic, valid held high, consumer always ready
    cyc = 0; acc = 0; outs = 0; last_acc = -1;
    v0 = 1'b1; or0 = 1'b1; d0 = K0'($urandom);
    while (outs < 5 && cyc < 400) begin
      if (cyc > 0 && last_acc == cyc - 1) d0 = K0'($urandom);
      if (r0 === 1'b1) begin
        if (acc < 5) begin
          ref_enc(64'(d0), K0, M0, 7, 5, es, ee, fin);
          qs.push_back(es);
          qe.push_back(ee);
          if (last_acc >= 0) check("b2b_period", 64'(cyc - last_acc), 64'(N0 + 2));
          last_acc = cyc;
          acc++;
        end else begin
          v0 = 1'b0;
        end
      end
      if (ov0 === 1'b1) begin
        if (qs.size() == 0) begin
          check("b2b_unexpected", 64'd1, 64'd0);
        end else begin
          check("b2b_sys", 64'(sys0), qs.pop_front());
          check("b2b_enc", 64'(enc0), qe.pop_front());
        end
        outs++;
      end
      @(negedge clk);
      cyc++;
    end
    v0 = 1'b0;
    or0 = 1'b0;
    check("b2b_counts", {32'(acc), 32'(outs)}, {32'd5, 32'd5});
    check("b2b_leftover", 64'(qs.size()), 64'd0);

    // Randomised blocks on the K=40, MEM=3 code
    for (int b = 0; b < 8; b++) begin
      dat = {32'($urandom), 32'($urandom)};
      dat = dat & ((64'd1 << K1) - 64'd1);
      run_block(1, dat, $sformatf("rnd%0d", b), gs, ge);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rsc_enc_param.md
RSC_ENC_PARAM -- requirements
Module: rsc_enc_param

Interface
REQ-001 SHALL have parameter K_LEN, default 16, information bits per block (2..4096).
REQ-002 SHALL have parameter MEM, default 2, encoder memory, i.e. constraint length minus 1 (1..6).
REQ-003 SHALL have parameter G_FB, default 3'b111 (octal 7), MEM+1-bit feedback polynomial.
  - Bit 0 is the current-input tap.
  - Bit j is the tap on the value delayed j cycles.
REQ-004 SHALL have parameter G_FF, default 3'b101 (octal 5), MEM+1-bit feedforward polynomial, same bit mapping as G_FB.
REQ-005 clk_p_i  input  1  single clock, rising edge.
REQ-006 reset_n_i  input  1  asynchronous, active-low reset.
REQ-007 in_valid_i  input  1  data_i holds a valid block.
REQ-008 in_ready_o  output  1  block accepted on in_valid_i & in_ready_o.
REQ-009 data_i  input  K_LEN  information block; bit K_LEN-1 is encoded first.
REQ-010 out_valid_o  output  1  encoded block available.
REQ-011 out_ready_i  input  1  consumer takes the block on out_valid_o & out_ready_i.
REQ-012 data_sys_o  output  K_LEN+MEM  systematic bits followed by MEM tail-input bits; MSB is the first bit.
REQ-013 data_enc_o  output  K_LEN+MEM  parity bits, including MEM tail parities; same ordering as data_sys_o.
REQ-014 busy_o  output  1  high in ENC or TAIL.

Function
REQ-015 SHALL implement FSM states IDLE, ENC, TAIL, DONE.
  - IDLE->ENC on input handshake.
  - ENC->TAIL after K_LEN bits.
  - TAIL->DONE after MEM bits.
  - DONE->IDLE on output handshake.
REQ-016 SHALL drive in_ready_o high only in IDLE; in_valid_i is ignored in all other states.
REQ-017 SHALL register data_i on acceptance; later changes to data_i SHALL NOT affect the block in flight.
REQ-018 SHALL process exactly one trellis step per cycle in ENC and TAIL.
  - Shift register s[1..MEM] is cleared to zero on every acceptance.
REQ-019 SHALL compute the feedback bit as a = u XOR (XOR over j=1..MEM of G_FB[j]&s[j]).
REQ-020 SHALL compute parity as p = (G_FF[0]&a) XOR (XOR over j=1..MEM of G_FF[j]&s[j]).
  - The register then shifts: s[1]<=a, s[j]<=s[j-1].
REQ-021 SHALL take u from the registered block, MSB first, during ENC.
REQ-022 SHALL, during TAIL, set u = XOR over j of G_FB[j]&s[j] (forcing a=0), and record that u as the systematic tail bit.
REQ-023 SHALL leave s all-zero after the last TAIL step (trellis terminated).
REQ-024 SHALL assert out_valid_o exactly K_LEN+MEM clock edges after the acceptance edge (default: 18).
REQ-025 SHALL hold data_sys_o, data_enc_o and out_valid_o stable while out_valid_o=1 and out_ready_i=0.
REQ-026 SHALL deassert out_valid_o on the edge the output handshake completes; in_ready_o rises on that same edge.
REQ-027 SHALL size the step counter as $clog2(K_LEN+MEM+1) bits.
  - Counter clears on acceptance; no wrap occurs within a block.
REQ-028 SHALL stop elaboration if G_FB[0]!=1 or either polynomial width differs from MEM+1.

Reset
REQ-029 SHALL, on reset_n_i low, asynchronously apply these values:
  - state IDLE; counter 0; s 0.
  - in_ready_o 0 while reset is asserted, 1 in the first cycle after release.
  - out_valid_o 0; busy_o 0; data_sys_o and data_enc_o 0.
REQ-030 SHALL abort any in-flight block on reset mid-operation, with no partial output after release.

Structure
REQ-031 SHALL place the FSM state enum and the default polynomial constants (RSC_G_FB_DEF=7, RSC_G_FF_DEF=5) in shared package rsc_pkg, for reuse by the turbo interleaver/decoder blocks.
REQ-032 SHALL isolate one trellis step (a, p, next s, tail u from s, u, mode) in combinational sub-module rsc_trellis_step, which the decoder reference model also uses.

Verification
REQ-033 Zero block: data_i=16'h0000 -> data_sys_o=18'h00000, data_enc_o=18'h00000, out_valid_o 18 cycles after acceptance.
REQ-034 Impulse, default parameters: data_i=16'h8000 -> data_sys_o=18'h20003, data_enc_o=18'h3B6D9, final s=0.
REQ-035 Backpressure: out_ready_i=0 for 10 cycles after out_valid_o -> outputs stable; in_ready_o stays 0; a second in_valid_i is not accepted until 1 cycle after the handshake.
REQ-036 Reset mid-ENC (cycle 5) -> all outputs at reset values; a new block of 16'hFFFF then encodes identically to a fresh run.
REQ-037 Randomised blocks, K_LEN=40 and MEM=3 with G_FB=4'b1011, G_FF=4'b1101 -> outputs match the reference model bit-exactly and every block ends in state 0.
REQ-038 Back-to-back traffic with in_valid_i held high and out_ready_i=1 -> one block per K_LEN+MEM+2 cycles, with no block dropped or duplicated.
